bram_byte2word_fifo_ctrl: RTL and testbench

//   Controller wrapping one 2048x9 / 512x36 dual-port block RAM as a byte-in, word-out FIFO.

---
 rtl/bram_byte2word_fifo_ctrl_if.sv | 23 ++
 rtl/bram_byte2word_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_bram_byte2word_fifo_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_byte2word_fifo_ctrl_if.sv
// rtl/bram_byte2word_fifo_ctrl_if.sv - byte-in / word-out stream handshake bundle
interface bram_byte2word_fifo_ctrl_if;
  logic [7:0]  s_data;
  logic        s_par;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_par;
  logic        m_valid;
  logic        m_ready;

  // Controller side: consumes bytes, produces words
  modport slave (
    input  s_data, s_par, s_valid, m_ready,
    output s_ready, m_data, m_par, m_valid
  );

  // Environment side: produces bytes, consumes words
  modport master (
    output s_data, s_par, s_valid, m_ready,
    input  s_ready, m_data, m_par, m_valid
  );
endinterface

// File: rtl/bram_byte2word_fifo_ctrl.sv
// rtl/bram_byte2word_fifo_ctrl.sv - byte-in word-out FIFO controller around a 2048x9 / 512x36 dual-port BRAM
module bram_byte2word_fifo_ctrl #(
  parameter int unsigned AFULL_BYTES  = 1792,
  parameter int unsigned AEMPTY_WORDS = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  bram_byte2word_fifo_ctrl_if.slave        fifo_io,
  output logic [11:0]                      occ_o,
  output logic                             s_afull_o,
  output logic                             m_aempty_o,
  output logic [10:0]                      ram_addra_o,
  output logic [7:0]                       ram_dia_o,
  output logic                             ram_dipa_o,
  output logic                             ram_ena_o,
  output logic                             ram_wea_o,
  output logic                             ram_ssra_o,
  output logic [8:0]                       ram_addrb_o,
  output logic [31:0]                      ram_dib_o,
  output logic [3:0]                       ram_dipb_o,
  output logic                             ram_enb_o,
  output logic                             ram_web_o,
  output logic                             ram_ssrb_o,
  input  logic [31:0]                      ram_dob_i,
  input  logic [3:0]                       ram_dopb_i
);

  localparam logic [11:0] AFULL_Q  = 12'(AFULL_BYTES);
  localparam logic [9:0]  AEMPTY_Q = 10'(AEMPTY_WORDS);
  localparam logic [11:0] DEPTH_Q  = 12'd2048;

  logic [10:0] wr_ptr_q, wr_ptr_d;
  logic [8:0]  rd_ptr_q, rd_ptr_d;
  logic [11:0] cnt_q, cnt_d;
  logic        m_valid_q, m_valid_d;

  logic        full;
  logic        s_ready;
  logic        push;
  logic        consume;
  logic        issue;
  logic [9:0]  words_avail;

  // Handshake decode: the word sitting on M_* still counts in cnt, so it is
  // excluded from what may be issued; partial words never qualify.
  always_comb begin
    full        = (cnt_q == DEPTH_Q);
    s_ready     = !full && !flush_i;
    push        = fifo_io.s_valid && s_ready;
    consume     = m_valid_q && fifo_io.m_ready;
    words_avail = cnt_q[11:2] - {9'd0, m_valid_q};
    issue       = (words_avail != 10'd0) && (!m_valid_q || fifo_io.m_ready) && !flush_i;
  end

  // Next-state: pointers advance per push/issue, space is freed only on consume
  always_comb begin
    wr_ptr_d  = wr_ptr_q + {10'd0, push};
    rd_ptr_d  = rd_ptr_q + {8'd0, issue};
    cnt_d     = cnt_q + {11'd0, push} - (consume ? 12'd4 : 12'd0);
    m_valid_d = issue ? 1'b1 : (fifo_io.m_ready ? 1'b0 : m_valid_q);
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      m_valid_d = 1'b0;
    end
  end

  // State registers; async reset discards anything in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Output and RAM port drive; DOB holds while ENB is low, so M_DATA is stable on stall
  always_comb begin
    fifo_io.s_ready = s_ready;
    fifo_io.m_valid = m_valid_q;
    fifo_io.m_data  = ram_dob_i;
    fifo_io.m_par   = ram_dopb_i;

    occ_o       = cnt_q;
    s_afull_o   = (cnt_q >= AFULL_Q);
    m_aempty_o  = (cnt_q[11:2] <= AEMPTY_Q);

    ram_addra_o = wr_ptr_q;
    ram_dia_o   = fifo_io.s_data;
    ram_dipa_o  = fifo_io.s_par;
    ram_ena_o   = push;
    ram_wea_o   = push;
    ram_ssra_o  = 1'b0;

    ram_addrb_o = rd_ptr_q;
    ram_dib_o   = 32'd0;
    ram_dipb_o  = 4'd0;
    ram_enb_o   = issue;
    ram_web_o   = 1'b0;
    ram_ssrb_o  = 1'b0;
  end

endmodule

// File: tb/tb_bram_byte2word_fifo_ctrl.sv
// tb/tb_bram_byte2word_fifo_ctrl.sv - scoreboard bench with behavioural BRAM for bram_byte2word_fifo_ctrl
module tb_bram_byte2word_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] occ;
  logic        s_afull, m_aempty;
  logic [10:0] ram_addra;
  logic [7:0]  ram_dia;
  logic        ram_dipa, ram_ena, ram_wea, ram_ssra;
  logic [8:0]  ram_addrb;
  logic [31:0] ram_dib;
  logic [3:0]  ram_dipb;
  logic        ram_enb, ram_web, ram_ssrb;
  logic [31:0] ram_dob = '0;
  logic [3:0]  ram_dopb = '0;

  bram_byte2word_fifo_ctrl_if bus();

  bram_byte2word_fifo_ctrl #(.AFULL_BYTES(1792), .AEMPTY_WORDS(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_io(bus),
    .occ_o(occ), .s_afull_o(s_afull), .m_aempty_o(m_aempty),
    .ram_addra_o(ram_addra), .ram_dia_o(ram_dia), .ram_dipa_o(ram_dipa),
    .ram_ena_o(ram_ena), .ram_wea_o(ram_wea), .ram_ssra_o(ram_ssra),
    .ram_addrb_o(ram_addrb), .ram_dib_o(ram_dib), .ram_dipb_o(ram_dipb),
    .ram_enb_o(ram_enb), .ram_web_o(ram_web), .ram_ssrb_o(ram_ssrb),
    .ram_dob_i(ram_dob), .ram_dopb_i(ram_dopb)
  );

  always #5 clk = ~clk;

  // Behavioural 2048x9 / 512x36 RAM, one-cycle registered read
  logic [8:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= {ram_dipa, ram_dia};
    if (ram_enb) begin
      ram_dob  <= {mem[{ram_addrb, 2'd3}][7:0], mem[{ram_addrb, 2'd2}][7:0],
                   mem[{ram_addrb, 2'd1}][7:0], mem[{ram_addrb, 2'd0}][7:0]};
      ram_dopb <= {mem[{ram_addrb, 2'd3}][8], mem[{ram_addrb, 2'd2}][8],
                   mem[{ram_addrb, 2'd1}][8], mem[{ram_addrb, 2'd0}][8]};
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: accepted bytes gathered into words in arrival order
  logic [8:0]  part_q [$];
  logic [35:0] exp_q [$];
  int          m_occ = 0;
  int          n_words = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    part_q.delete();
    exp_q.delete();
    m_occ = 0;
  endtask

  task automatic model_push(input logic [8:0] b);
    logic [35:0] w;
    part_q.push_back(b);
    m_occ++;
    if (part_q.size() == 4) begin
      w = {part_q[3][8], part_q[2][8], part_q[1][8], part_q[0][8],
           part_q[3][7:0], part_q[2][7:0], part_q[1][7:0], part_q[0][7:0]};
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  // Monitor: sample between edges, check state, then account for the coming edge
  logic        prev_hold = 1'b0;
  logic [35:0] prev_word = '0;
  initial begin
    logic [35:0] w;
    logic        do_push, do_cons;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        chk("occ", 64'(occ), 64'(m_occ));
        chk("s_afull", 64'(s_afull), 64'(m_occ >= 1792));
        chk("m_aempty", 64'(m_aempty), 64'((m_occ / 4) <= 1));
        chk("s_ready", 64'(bus.s_ready), 64'((m_occ != 2048) && !flush));
        if (prev_hold && bus.m_valid)
          chk("hold_stable", 64'({bus.m_par, bus.m_data}), 64'(prev_word));
        if (flush) begin
          model_clear();
          prev_hold = 1'b0;
        end else begin
          do_push = bus.s_valid && bus.s_ready;
          do_cons = bus.m_valid && bus.m_ready;
          if (do_cons) begin
            n_words++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL word_unexpected actual=%0h expected=none t=%0t", {bus.m_par, bus.m_data}, $time);
            end else begin
              w = exp_q.pop_front();
              chk("word", 64'({bus.m_par, bus.m_data}), 64'(w));
            end
            m_occ -= 4;
          end
          if (do_push) model_push({bus.s_par, bus.s_data});
          prev_hold = bus.m_valid && !bus.m_ready;
          prev_word = {bus.m_par, bus.m_data};
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.s_data  = '0;
    bus.s_par   = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_s_afull", 64'(s_afull), 64'd0);
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic p);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_par   = p;
    step();
  endtask

  initial begin
    logic [7:0] t1d [4];
    logic       t1p [4];
    int         n, maxocc, enb_seen;
    logic [15:0] ctr;

    t1d[0] = 8'h11; t1d[1] = 8'h22; t1d[2] = 8'h33; t1d[3] = 8'h44;
    t1p[0] = 1'b1;  t1p[1] = 1'b0;  t1p[2] = 1'b0;  t1p[3] = 1'b1;

    // T1: single word, latency and lane mapping
    do_reset();
    chk("ram_const", 64'({ram_ssra, ram_ssrb, ram_web, ram_dib, ram_dipb}), 64'd0);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_byte(t1d[i], t1p[i]);
    bus.s_valid = 1'b0;
    chk("t1_issue", 64'(ram_enb), 64'd1);
    chk("t1_no_valid_yet", 64'(bus.m_valid), 64'd0);
    step();
    chk("t1_m_valid", 64'(bus.m_valid), 64'd1);
    chk("t1_m_data", 64'(bus.m_data), 64'h44332211);
    chk("t1_m_par", 64'(bus.m_par), 64'b1001);
    step();
    chk("t1_occ_after", 64'(occ), 64'd0);

    // T2: partial word never leaves
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 1'($urandom));
    bus.s_valid = 1'b0;
    enb_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (ram_enb || bus.m_valid) enb_seen++;
      step();
    end
    chk("t2_no_read", 64'(enb_seen), 64'd0);
    chk("t2_occ", 64'(occ), 64'd3);

    // T3: fill to 2048 with consumer stalled, then drain back-to-back
    do_reset();
    for (int i = 0; i < 2048; i++) drive_byte(8'($urandom), 1'($urandom));
    chk("t3_full_occ", 64'(occ), 64'd2048);
    chk("t3_s_ready", 64'(bus.s_ready), 64'd0);
    chk("t3_s_afull", 64'(s_afull), 64'd1);
    drive_byte(8'hEE, 1'b1);
    bus.s_valid = 1'b0;
    chk("t3_2049_ignored", 64'(occ), 64'd2048);
    bus.m_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.m_valid) n++;
      else if (n > 0) break;
      step();
    end
    chk("t3_burst_len", 64'(n), 64'd512);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // T4: continuous streaming across pointer wrap
    do_reset();
    bus.m_ready = 1'b1;
    maxocc = 0;
    n_words = 0;
    ctr = '0;
    for (int i = 0; i < 3200; i++) begin
      drive_byte(ctr[7:0], ^ctr);
      ctr++;
      if (int'(occ) > maxocc) maxocc = int'(occ);
    end
    bus.s_valid = 1'b0;
    repeat (10) step();
    chk("t4_max_occ", 64'(maxocc <= 8), 64'd1);
    chk("t4_words", 64'(n_words), 64'd800);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // T5: random valid / ready with stall-stability checks in the monitor
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.s_valid = 1'($urandom);
      bus.s_data  = 8'($urandom);
      bus.s_par   = 1'($urandom);
      bus.m_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (20) step();
    chk("t5_drained", 64'(exp_q.size()), 64'd0);

    // T6: flush with a held word, then async reset mid-stream
    do_reset();
    for (int i = 0; i < 10; i++) drive_byte(8'($urandom), 1'($urandom));
    bus.s_valid = 1'b0;
    step();
    chk("t6_pre_valid", 64'(bus.m_valid), 64'd1);
    chk("t6_pre_occ", 64'(occ), 64'd10);
    flush = 1'b1;
    bus.s_valid = 1'b1;
    step();
    flush = 1'b0;
    bus.s_valid = 1'b0;
    chk("t6_flush_occ", 64'(occ), 64'd0);
    chk("t6_flush_valid", 64'(bus.m_valid), 64'd0);
    chk("t6_flush_addra", 64'(ram_addra), 64'd0);
    for (int i = 0; i < 7; i++) drive_byte(8'($urandom), 1'($urandom));
    chk("t6_mid_valid", 64'(bus.m_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("t6_async_valid", 64'(bus.m_valid), 64'd0);
    chk("t6_async_occ", 64'(occ), 64'd0);
    bus.s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6_post_occ", 64'(occ), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
